uart_reply_tx: RTL and testbench

Frame transmitter for the host command link: serialises 8-byte reply/status frames in the same format the FPGA accepts from the host (AA BB CC, command, three payload bytes, trailer 0x80|command), so host software parses replies with the identical decoder. Sits between the status/readback logic and the UART byte transmitter, all on the 50 MHz clock. Holds one pending frame while another is on the wire and guards against a stalled UART with a per-byte timeout.

---
 rtl/uart_reply_tx_if.sv | 37 +++
 rtl/uart_reply_tx.sv | 186 ++++++++++++++++++
 tb/tb_uart_reply_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reply_tx_if.sv
// Reply-frame link bundle: request side (status logic -> framer) and UART byte side.
// Latency: none, wires only.
// Backpressure: sendReady gates requests; uartTxDone paces bytes.
//
// Ports (as seen from the framer, modport slave):
//   sendReq/sendCmd/sendPayload  in   frame request, command and 24-bit payload
//   sendReady                    out  pending slot empty
//   uartTxDV/uartTxData          out  byte strobe and byte to UART TX
//   uartTxDone                   in   UART TX finished the current byte
//   busy/frameDone/timeoutErr    out  status and one-cycle event pulses
//   framesSent                   out  completed-frame counter
`timescale 1ns/1ps
interface uart_reply_tx_if;
   logic        sendReq;
   logic [7:0]  sendCmd;
   logic [23:0] sendPayload;
   logic        sendReady;
   logic        uartTxDV;
   logic [7:0]  uartTxData;
   logic        uartTxDone;
   logic        busy;
   logic        frameDone;
   logic        timeoutErr;
   logic [15:0] framesSent;

   // Requester / UART side
   modport master (
      output sendReq, sendCmd, sendPayload, uartTxDone,
      input  sendReady, uartTxDV, uartTxData, busy, frameDone, timeoutErr, framesSent
   );

   // Frame transmitter side
   modport slave (
      input  sendReq, sendCmd, sendPayload, uartTxDone,
      output sendReady, uartTxDV, uartTxData, busy, frameDone, timeoutErr, framesSent
   );
endinterface

// File: rtl/uart_reply_tx.sv
// Serialises 8-byte reply frames AA BB CC cmd p2 p1 p0 {1,cmd[6:0]} to a UART byte transmitter.
// Latency: request sampled at edge N -> first byte strobe after edge N+1; next byte strobe the cycle after uartTxDone.
// Backpressure: one pending frame slot; requests while sendReady=0 are dropped. A byte not acknowledged within DONE_TIMEOUT cycles aborts the frame.
//
// Ports:
//   clk_50   in  50 MHz system clock
//   reset_n  in  asynchronous active-low reset
//   bus      uart_reply_tx_if.slave: request inputs, UART byte handshake, status outputs
`timescale 1ns/1ps
module uart_reply_tx #(
   parameter int DONE_TIMEOUT = 100000   // cycles allowed per byte, counted from its strobe; must be >= 2
) (
   input logic               clk_50,
   input logic               reset_n,
   uart_reply_tx_if.slave    bus
);

   localparam int CNT_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DONE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [23:0] payload;
   } req_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           r_state;
   logic             r_holdValid;
   req_t             r_hold;
   logic [63:0]      r_frame;        // byte on the wire is always r_frame[63:56]
   logic [2:0]       r_byteIdx;
   logic [CNT_W-1:0] r_tmoCnt;
   logic             r_txDV;
   logic [7:0]       r_txData;
   logic             r_frameDone;
   logic             r_tmoErr;
   logic [15:0]      r_framesSent;
   logic             r_sendReady;
   logic             r_busy;

   // ------------------------------------------------------------------
   // Next-state values
   // ------------------------------------------------------------------
   state_t           w_nState;
   logic             w_nHoldValid;
   req_t             w_nHold;
   logic [63:0]      w_nFrame;
   logic [2:0]       w_nByteIdx;
   logic [CNT_W-1:0] w_nTmoCnt;
   logic             w_nTxDV;
   logic [7:0]       w_nTxData;
   logic             w_nFrameDone;
   logic             w_nTmoErr;
   logic [15:0]      w_nFramesSent;
   logic             w_accept;
   logic [63:0]      w_loadFrame;

   assign w_accept = bus.sendReq && !r_holdValid;

   // Trailer repeats the command with bit 7 forced high so the host decoder
   // can tell it apart from header bytes.
   assign w_loadFrame = {8'hAA, 8'hBB, 8'hCC, r_hold.cmd, r_hold.payload,
                         1'b1, r_hold.cmd[6:0]};

   always_comb begin
      w_nState      = r_state;
      w_nHoldValid  = r_holdValid;
      w_nHold       = r_hold;
      w_nFrame      = r_frame;
      w_nByteIdx    = r_byteIdx;
      w_nTmoCnt     = r_tmoCnt;
      w_nTxDV       = 1'b0;
      w_nTxData     = r_txData;
      w_nFrameDone  = 1'b0;
      w_nTmoErr     = 1'b0;
      w_nFramesSent = r_framesSent;

      // Slot write. Acceptance needs an empty slot, so it never collides
      // with the IDLE load below, which only happens while the slot is full.
      if (w_accept) begin
         w_nHoldValid    = 1'b1;
         w_nHold.cmd     = bus.sendCmd;
         w_nHold.payload = bus.sendPayload;
      end

      case (r_state)
         IDLE: begin
            if (r_holdValid) begin
               w_nFrame     = w_loadFrame;
               w_nHoldValid = 1'b0;
               w_nByteIdx   = 3'd0;
               w_nTmoCnt    = '0;
               w_nTxDV      = 1'b1;
               w_nTxData    = w_loadFrame[63:56];
               w_nState     = SEND;
            end
         end

         // The strobe is registered, so it is high exactly while in SEND.
         // The SEND cycle is cycle 0 of the byte's timeout budget.
         SEND: begin
            w_nTmoCnt = r_tmoCnt + CNT_ONE;
            w_nState  = WAIT;
         end

         WAIT: begin
            if (bus.uartTxDone) begin
               // done takes priority over a simultaneous timeout
               if (r_byteIdx == 3'd7) begin
                  w_nFrameDone  = 1'b1;
                  w_nFramesSent = r_framesSent + 16'd1;
                  w_nState      = IDLE;
               end else begin
                  w_nFrame   = {r_frame[55:0], 8'h00};
                  w_nByteIdx = r_byteIdx + 3'd1;
                  w_nTmoCnt  = '0;
                  w_nTxDV    = 1'b1;
                  w_nTxData  = r_frame[55:48];
                  w_nState   = SEND;
               end
            end else if (r_tmoCnt == TMO_LAST) begin
               // abandon the rest of the frame; the pending slot is untouched
               w_nTmoErr = 1'b1;
               w_nState  = IDLE;
            end else begin
               w_nTmoCnt = r_tmoCnt + CNT_ONE;
            end
         end

         default: begin
            w_nState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_holdValid  <= 1'b0;
         r_hold       <= '0;
         r_frame      <= '0;
         r_byteIdx    <= 3'd0;
         r_tmoCnt     <= '0;
         r_txDV       <= 1'b0;
         r_txData     <= 8'h00;
         r_frameDone  <= 1'b0;
         r_tmoErr     <= 1'b0;
         r_framesSent <= 16'h0000;
         r_sendReady  <= 1'b1;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_nState;
         r_holdValid  <= w_nHoldValid;
         r_hold       <= w_nHold;
         r_frame      <= w_nFrame;
         r_byteIdx    <= w_nByteIdx;
         r_tmoCnt     <= w_nTmoCnt;
         r_txDV       <= w_nTxDV;
         r_txData     <= w_nTxData;
         r_frameDone  <= w_nFrameDone;
         r_tmoErr     <= w_nTmoErr;
         r_framesSent <= w_nFramesSent;
         // status flags are registered copies of the next-cycle state
         r_sendReady  <= !w_nHoldValid;
         r_busy       <= (w_nState != IDLE);
      end
   end

   assign bus.sendReady  = r_sendReady;
   assign bus.uartTxDV   = r_txDV;
   assign bus.uartTxData = r_txData;
   assign bus.busy       = r_busy;
   assign bus.frameDone  = r_frameDone;
   assign bus.timeoutErr = r_tmoErr;
   assign bus.framesSent = r_framesSent;

endmodule

// File: tb/tb_uart_reply_tx.sv
// Directed bench for uart_reply_tx: frame contents, latencies, slot, timeout, wrap and reset.
// Inputs driven and outputs sampled on the falling edge; DUT registers on the rising edge.
// UART TX behaviour is emulated inline by pulsing uartTxDone a chosen number of cycles after each strobe.
`timescale 1ns/1ps
module tb_uart_reply_tx;
   localparam int TMO = 16;

   logic clk_50  = 1'b0;
   logic reset_n = 1'b0;

   uart_reply_tx_if u();

   uart_reply_tx #(.DONE_TIMEOUT(TMO)) dut (
      .clk_50  (clk_50),
      .reset_n (reset_n),
      .bus     (u)
   );

   always #10 clk_50 = ~clk_50;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_fd     = 0;
   int n_te     = 0;
   logic [7:0] txq[$];

   always @(posedge clk_50) cyc <= cyc + 1;

   always @(negedge clk_50) begin
      if (u.uartTxDV === 1'b1) txq.push_back(u.uartTxData);
      if (u.frameDone === 1'b1) n_fd++;
      if (u.timeoutErr === 1'b1) n_te++;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_50);
   endtask

   task automatic wait_strobe(input int budget, output int at);
      at = -1;
      for (int i = 0; i <= budget; i++) begin
         if (u.uartTxDV === 1'b1) begin
            at = cyc;
            return;
         end
         tick();
      end
   endtask

   task automatic request(input logic [7:0] cmd, input logic [23:0] pay);
      u.sendCmd     = cmd;
      u.sendPayload = pay;
      u.sendReq     = 1'b1;
      tick();
      u.sendReq     = 1'b0;
   endtask

   // delay >= 1: a done driven in the strobe cycle itself lands in SEND
   task automatic send_done(input int delay);
      repeat (delay) tick();
      u.uartTxDone = 1'b1;
      tick();
      u.uartTxDone = 1'b0;
   endtask

   task automatic serve_bytes(input int nbytes, input int delay);
      int s;
      for (int i = 0; i < nbytes; i++) begin
         wait_strobe(40, s);
         if (s < 0) return;
         send_done(delay);
      end
   endtask

   task automatic grab_frame(output logic [63:0] w, output int n);
      n = txq.size();
      w = '0;
      for (int i = 0; i < 8; i++)
         if (txq.size() > 0) w = {w[55:0], txq.pop_front()};
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0, s, s2, te, n, fd0;
      logic [63:0] w;

      u.sendReq = 1'b0; u.sendCmd = 8'h00; u.sendPayload = 24'h0; u.uartTxDone = 1'b0;
      repeat (3) tick();

      // ---------------- reset values ----------------
      check_val("rst sendReady",  64'(u.sendReady),  64'h1);
      check_val("rst busy",       64'(u.busy),       64'h0);
      check_val("rst uartTxDV",   64'(u.uartTxDV),   64'h0);
      check_val("rst uartTxData", 64'(u.uartTxData), 64'h0);
      check_val("rst frameDone",  64'(u.frameDone),  64'h0);
      check_val("rst timeoutErr", 64'(u.timeoutErr), 64'h0);
      check_val("rst framesSent", 64'(u.framesSent), 64'h0);
      reset_n = 1'b1;
      repeat (2) tick();

      // ---------------- single frame ----------------
      t0 = cyc;
      request(8'h05, 24'h00001A);
      check_val("t1 ready low after accept", 64'(u.sendReady), 64'h0);
      check_val("t1 busy still low",         64'(u.busy),      64'h0);
      wait_strobe(10, s);
      check_val("t1 first strobe latency",   64'(s - t0),      64'd2);
      check_val("t1 ready back at strobe",   64'(u.sendReady), 64'h1);
      check_val("t1 first byte",             64'(u.uartTxData), 64'hAA);
      serve_bytes(8, 10);
      check_val("t1 frameDone",  64'(u.frameDone),  64'h1);
      check_val("t1 busy end",   64'(u.busy),       64'h0);
      check_val("t1 framesSent", 64'(u.framesSent), 64'h1);
      tick();
      check_val("t1 frameDone one cycle", 64'(u.frameDone), 64'h0);
      grab_frame(w, n);
      check_val("t1 byte count", 64'(n), 64'd8);
      check_val("t1 frame",      w,      64'hAABBCC0500001A85);
      check_val("t1 frameDone pulses", 64'(n_fd), 64'd1);

      // ---------------- back-to-back with full slot ----------------
      request(8'h11, 24'h0123F8);
      wait_strobe(10, s);
      request(8'h92, 24'h000000);
      check_val("t2 second accepted", 64'(u.sendReady), 64'h0);
      request(8'h33, 24'h444444);          // slot full: dropped
      check_val("t2 ready still low", 64'(u.sendReady), 64'h0);
      send_done(3);
      serve_bytes(7, 3);
      check_val("t2 frame1 done",      64'(u.frameDone), 64'h1);
      check_val("t2 idle between",     64'(u.busy),      64'h0);
      check_val("t2 slot held",        64'(u.sendReady), 64'h0);
      te = cyc;
      wait_strobe(10, s2);
      check_val("t2 inter-frame gap",  64'(s2 - te),     64'd1);
      check_val("t2 ready after load", 64'(u.sendReady), 64'h1);
      serve_bytes(8, 2);
      check_val("t2 framesSent", 64'(u.framesSent), 64'h3);
      repeat (30) tick();
      check_val("t2 no third frame busy", 64'(u.busy), 64'h0);
      grab_frame(w, n);
      check_val("t2 frame1", w, 64'hAABBCC110123F891);
      grab_frame(w, n);
      check_val("t2 frame2", w, 64'hAABBCC9200000092);
      check_val("t2 dropped request", 64'(txq.size()), 64'd0);
      check_val("t2 frameDone pulses", 64'(n_fd), 64'd3);

      // ---------------- timeout after byte 3 ----------------
      request(8'h44, 24'h010203);
      serve_bytes(3, 2);
      wait_strobe(10, s);
      te = -1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (u.timeoutErr === 1'b1) begin
            te = cyc;
            break;
         end
      end
      check_val("t3 timeout latency", 64'(te - s),      64'd16);
      check_val("t3 busy after abort", 64'(u.busy),     64'h0);
      check_val("t3 framesSent kept", 64'(u.framesSent), 64'h3);
      check_val("t3 no frameDone",    64'(u.frameDone), 64'h0);
      tick();
      check_val("t3 timeoutErr one cycle", 64'(u.timeoutErr), 64'h0);
      repeat (20) tick();
      check_val("t3 bytes sent before abort", 64'(txq.size()), 64'd4);
      check_val("t3 timeout pulses", 64'(n_te), 64'd1);
      txq.delete();
      request(8'h7E, 24'hABCDEF);
      serve_bytes(8, 4);
      check_val("t3 framesSent after recover", 64'(u.framesSent), 64'h4);
      grab_frame(w, n);
      check_val("t3 recovered frame", w, 64'hAABBCC7EABCDEFFE);

      // ---------------- stray done and done/timeout collision ----------------
      u.uartTxDone = 1'b1;                 // stray in IDLE
      tick();
      u.uartTxDone = 1'b0;
      repeat (5) tick();
      check_val("t4 idle stray busy",  64'(u.busy),      64'h0);
      check_val("t4 idle stray bytes", 64'(txq.size()),  64'd0);
      request(8'hC3, 24'h5A5A5A);
      wait_strobe(10, s);
      u.uartTxDone = 1'b1;                 // stray in SEND
      tick();
      u.uartTxDone = 1'b0;
      repeat (14) tick();
      check_val("t4 send stray ignored", 64'(txq.size()), 64'd1);
      u.uartTxDone = 1'b1;                 // coincides with the last timeout cycle
      tick();
      u.uartTxDone = 1'b0;
      check_val("t4 collision no error", 64'(u.timeoutErr), 64'h0);
      check_val("t4 collision strobe",   64'(u.uartTxDV),   64'h1);
      check_val("t4 collision timing",   64'(cyc - s),      64'd16);
      serve_bytes(8, 2);
      check_val("t4 framesSent", 64'(u.framesSent), 64'h5);
      check_val("t4 timeout pulses", 64'(n_te), 64'd1);
      grab_frame(w, n);
      check_val("t4 frame", w, 64'hAABBCCC35A5A5AC3);

      // ---------------- counter wrap ----------------
      force dut.r_framesSent = 16'hFFFF;
      tick();
      release dut.r_framesSent;
      tick();
      check_val("t5 preload held", 64'(u.framesSent), 64'hFFFF);
      request(8'h01, 24'h000002);
      serve_bytes(8, 1);
      check_val("t5 wrap frameDone", 64'(u.frameDone),  64'h1);
      check_val("t5 wrap to zero",   64'(u.framesSent), 64'h0);
      grab_frame(w, n);
      check_val("t5 frame", w, 64'hAABBCC0100000281);

      // ---------------- reset during byte 4 ----------------
      request(8'h66, 24'h102030);
      serve_bytes(4, 2);
      wait_strobe(10, s);
      request(8'h77, 24'h000001);          // queued frame must be lost too
      check_val("t6 queued before reset", 64'(u.sendReady), 64'h0);
      tick();
      fd0 = n_fd;
      #5 reset_n = 1'b0;
      #1;
      check_val("t6 rst sendReady",  64'(u.sendReady),  64'h1);
      check_val("t6 rst busy",       64'(u.busy),       64'h0);
      check_val("t6 rst uartTxDV",   64'(u.uartTxDV),   64'h0);
      check_val("t6 rst uartTxData", 64'(u.uartTxData), 64'h0);
      check_val("t6 rst framesSent", 64'(u.framesSent), 64'h0);
      check_val("t6 rst frameDone",  64'(u.frameDone),  64'h0);
      check_val("t6 rst timeoutErr", 64'(u.timeoutErr), 64'h0);
      tick();
      reset_n = 1'b1;
      txq.delete();
      repeat (40) tick();
      check_val("t6 no strobe after release", 64'(txq.size()), 64'd0);
      check_val("t6 idle after release",      64'(u.busy),      64'h0);
      check_val("t6 no frameDone",            64'(n_fd - fd0),  64'd0);
      check_val("t6 no timeoutErr",           64'(n_te),        64'd1);
      request(8'h08, 24'h0000FF);
      serve_bytes(8, 1);
      check_val("t6 framesSent after reset", 64'(u.framesSent), 64'h1);
      grab_frame(w, n);
      check_val("t6 frame", w, 64'hAABBCC080000FF88);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
